md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo requests from the EX stage, runs a fixed-latency multi-cycle operation, and owns the HI/LO registers. It drives a stall request consumed by the ID-stage hazard logic, so that any MDU-class instruction in ID waits while the unit is busy or is being started.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- start_EX  in  1  request valid this cycle (EX stage)
- MDOp_EX  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- A_EX  in  32  rs operand (forwarded)
- B_EX  in  32  rt operand (forwarded)
- MDUse_ID  in  1  instruction in ID is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle operation in flight
- HI  out  32  HI register
- LO  out  32  LO register
- MDStall  out  1  stall request to ID/PC/IF-ID

## Operation
- States: IDLE, RUN.
- IDLE + start_EX + MDOp in {1..4}: at the edge, latch the computed 64-bit result into pend_hi/pend_lo, load cnt = MULT_CYCLES or DIV_CYCLES, go to RUN.
- IDLE + start_EX + MDOp 5/6: at the edge, write A_EX to HI (mthi) or LO (mtlo). Stay in IDLE; busy stays 0.
- IDLE + start_EX + MDOp 0 or 7: no effect.
- RUN: cnt decrements each edge. At the edge where cnt==1, write pend_hi→HI and pend_lo→LO, then return to IDLE.
- start_EX in RUN is ignored. The bench asserts it never occurs; MDStall prevents it.
- Arithmetic:
  - mult: {HI,LO} = signed A×B.
  - multu: {HI,LO} = unsigned A×B.
  - div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of A.
  - divu: unsigned quotient and remainder.
  - Overflow case 0x80000000 / −1: LO=0x80000000, HI=0.
- busy = (state==RUN).
- MDStall = MDUse_ID & (busy | (start_EX & MDOp_EX in {1..4})). Purely combinational.
- Reset (any time, including mid-RUN): state=IDLE, cnt=0, HI=0, LO=0, pend regs=0, busy=0, MDStall=MDUse_ID & start-term only. An aborted operation never writes HI/LO.

## Timing
- Start edge E0. busy=1 from after E0 through the cycle before E(N), where N = MULT_CYCLES or DIV_CYCLES; busy is high for exactly N cycles.
- HI/LO take new values at E(N) and are visible in the following cycle. busy falls at the same edge.
- Earliest next multi-cycle start is accepted at E(N+1). mfhi/mflo in ID is released in the cycle after E(N).
- mthi/mtlo latency is 1 edge; its value is readable in the next cycle.
- HI/LO outputs are registered; there is no bypass of pend values.

## Configuration
- MDU_DIVZERO_GUARD_EN defined:
  - div/divu with B_EX==0 does not enter RUN; busy stays 0.
  - HI/LO are unchanged.
  - MDStall does not include that start term.
- MDU_DIVZERO_GUARD_EN undefined:
  - Divide-by-zero runs the full DIV_CYCLES.
  - Result is HI=A_EX, LO=0xFFFFFFFF.
  - Never X in either case.

## Structure
- Shared package/header (alongside the existing control defines):
  - MDOp codes (MD_NONE..MD_MTLO).
  - Default MULT_CYCLES/DIV_CYCLES.
  - State encodings IDLE/RUN.
- One sub-module, md_calc: combinational, takes MDOp, A, B and returns a 64-bit {hi,lo}. Contains signed/unsigned mult/div, the overflow case, and the divide-by-zero value.
- md_sched holds the FSM, counter, pend, HI/LO and stall logic.

## Test plan
- mult A=0xFFFFFFFD, B=7 → busy 5 cycles; after E5, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE at E5. div A=0xFFFFFFF9, B=2 → after E10, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- MDUse_ID=1 held during a div → MDStall=1 in the start cycle and all 10 busy cycles; 0 in the cycle after E10.
- mthi A=0x12345678 in IDLE → HI=0x12345678 next cycle, busy never asserts. A start_EX pulse in RUN leaves cnt and the pending result unchanged.
- Reset low at cycle 3 of a mult → busy=0, HI=LO=0 immediately. After release, no late HI/LO write occurs.
- div B=0:
  - With MDU_DIVZERO_GUARD_EN: busy stays 0; HI/LO keep prior values.
  - Without: busy 10 cycles; then HI=A, LO=0xFFFFFFFF.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// MDOp codes, default latencies and FSM state encodings.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic logic is_run_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// Divide-by-zero yields {a, 32'hFFFFFFFF}; 0x80000000/-1 yields {0, 0x80000000}.
module md_calc
    import md_sched_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic        b_zero;
    logic        s_ovf;
    logic [31:0] b_nz;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [63:0] smul;
    logic [63:0] umul;

    assign b_zero = (b == 32'd0);
    assign b_nz   = b_zero ? 32'd1 : b;
    assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul = {32'd0, a} * {32'd0, b};

    assign uq = a / b_nz;
    assign ur = a % b_nz;

    // Signed divide on magnitudes: quotient truncates toward zero,
    // remainder follows the dividend's sign.
    assign a_mag = a[31] ? (~a + 32'd1) : a;
    assign b_mag = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
    assign mag_q = a_mag / b_mag;
    assign mag_r = a_mag % b_mag;
    assign sq    = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign sr    = a[31] ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:  res = smul;
            MD_MULTU: res = umul;
            MD_DIV: begin
                if (b_zero)
                    res = {a, 32'hFFFF_FFFF};
                else if (s_ovf)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {sr, sq};
            end
            MD_DIVU: begin
                if (b_zero)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {ur, uq};
            end
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MDU scheduler owning HI/LO and the ID-stage stall request.
// Optional MDU_DIVZERO_GUARD_EN: divide-by-zero is dropped instead of run.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_EX,
    input  logic [2:0]  MDOp_EX,
    input  logic [31:0] A_EX,
    input  logic [31:0] B_EX,
    input  logic        MDUse_ID,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MDStall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    md_state_e   state_q;
    md_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] calc_res;

    logic dz_block;
    logic run_req;
    logic go;
    logic mt_go;
    logic done;

    md_calc u_calc (
        .op  (MDOp_EX),
        .a   (A_EX),
        .b   (B_EX),
        .res (calc_res)
    );

`ifdef MDU_DIVZERO_GUARD_EN
    assign dz_block = is_div_op(MDOp_EX) && (B_EX == 32'd0);
`else
    assign dz_block = 1'b0;
`endif

    assign run_req = start_EX && is_run_op(MDOp_EX) && !dz_block;
    assign go      = run_req && (state_q == IDLE);
    assign mt_go   = start_EX && (state_q == IDLE) &&
                     ((MDOp_EX == MD_MTHI) || (MDOp_EX == MD_MTLO));
    assign done    = (state_q == RUN) && (cnt_q == ONE);

    assign busy    = (state_q == RUN);
    assign MDStall = MDUse_ID && (busy || run_req);
    assign HI      = hi_q;
    assign LO      = lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go) state_d = RUN;
            RUN:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            if (go) begin
                pend_hi_q <= calc_res[63:32];
                pend_lo_q <= calc_res[31:0];
                cnt_q     <= is_div_op(MDOp_EX) ? DIV_LD : MULT_LD;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - ONE;
            end

            // Results only become architectural on the final RUN edge.
            if (done) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end else if (mt_go) begin
                if (MDOp_EX == MD_MTHI)
                    hi_q <= A_EX;
                else
                    lo_q <= A_EX;
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO queued at issue,
// popped by a monitor when busy falls.
`timescale 1ns/1ps
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_EX = 1'b0;
    logic [2:0]  MDOp_EX = 3'd0;
    logic [31:0] A_EX = 32'd0;
    logic [31:0] B_EX = 32'd0;
    logic        MDUse_ID = 1'b0;
    logic        busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    logic prev_busy = 1'b0;

    md_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start_EX (start_EX),
        .MDOp_EX  (MDOp_EX),
        .A_EX     (A_EX),
        .B_EX     (B_EX),
        .MDUse_ID (MDUse_ID),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .MDStall  (MDStall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && prev_busy && !busy) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_result", {HI, LO}, 64'hx);
            else
                check("sb_hilo", {HI, LO}, exp_q.pop_front());
        end
        prev_busy <= busy;
    end

    task automatic run_md(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int ncyc,
                          input bit pulse);
        int n;
        bit stall_ok;
        @(negedge clk);
        start_EX = 1'b1;
        MDOp_EX  = op;
        A_EX     = a;
        B_EX     = b;
        MDUse_ID = 1'b1;
        exp_q.push_back(res);
        #1;
        check({name, "_stall_start"}, {63'd0, MDStall}, 64'd1);
        @(negedge clk);
        start_EX = 1'b0;
        MDOp_EX  = MD_NONE;
        A_EX     = $urandom;
        B_EX     = $urandom;
        n = 0;
        stall_ok = 1'b1;
        while (busy && n < 40) begin
            n++;
            if (!MDStall) stall_ok = 1'b0;
            if (pulse && n == 2) begin
                start_EX = 1'b1;
                MDOp_EX  = MD_DIVU;
                A_EX     = 32'd100;
                B_EX     = 32'd3;
            end
            @(negedge clk);
            start_EX = 1'b0;
            MDOp_EX  = MD_NONE;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(ncyc));
        check({name, "_stall_run"}, {63'd0, stall_ok}, 64'd1);
        check({name, "_stall_release"}, {63'd0, MDStall}, 64'd0);
        MDUse_ID = 1'b0;
    endtask

    task automatic move_to(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [63:0] hilo);
        @(negedge clk);
        start_EX = 1'b1;
        MDOp_EX  = op;
        A_EX     = a;
        B_EX     = $urandom;
        #1;
        check({name, "_busy_start"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        start_EX = 1'b0;
        MDOp_EX  = MD_NONE;
        check({name, "_hilo"}, {HI, LO}, hilo);
        check({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        bit late;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_stall", {63'd0, MDStall}, 64'd0);
        rst_n = 1'b1;

        run_md("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7,
               64'hFFFF_FFFF_FFFF_FFEB, 5, 1'b0);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2,
               64'h0000_0001_FFFF_FFFE, 5, 1'b0);
        run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0);
        run_md("divu", MD_DIVU, 32'd7, 32'd2,
               64'h0000_0001_0000_0003, 10, 1'b0);
        run_md("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE,
               64'h0000_0001_FFFF_FFFD, 10, 1'b0);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 10, 1'b0);
        run_md("mult_pulse", MD_MULT, 32'h0001_0000, 32'h0001_0000,
               64'h0000_0001_0000_0000, 5, 1'b1);

        move_to("mthi", MD_MTHI, 32'h1234_5678, 64'h1234_5678_0000_0000);
        move_to("mtlo", MD_MTLO, 32'hCAFE_F00D, 64'h1234_5678_CAFE_F00D);

        // Abort a mult in its third busy cycle.
        @(negedge clk);
        start_EX = 1'b1;
        MDOp_EX  = MD_MULT;
        A_EX     = 32'd5;
        B_EX     = 32'd6;
        @(negedge clk);
        start_EX = 1'b0;
        MDOp_EX  = MD_NONE;
        repeat (2) @(negedge clk);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        MDUse_ID = 1'b1;
        start_EX = 1'b1;
        MDOp_EX  = MD_MULT;
        #1;
        check("abort_stall_in_reset", {63'd0, MDStall}, 64'd1);
        start_EX = 1'b0;
        MDOp_EX  = MD_NONE;
        MDUse_ID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        late = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || HI != 32'd0 || LO != 32'd0) late = 1'b1;
        end
        check("abort_no_late_write", {63'd0, late}, 64'd0);

        move_to("mthi2", MD_MTHI, 32'hA5A5_A5A5, 64'hA5A5_A5A5_0000_0000);
`ifdef MDU_DIVZERO_GUARD_EN
        @(negedge clk);
        start_EX = 1'b1;
        MDOp_EX  = MD_DIV;
        A_EX     = 32'h55;
        B_EX     = 32'd0;
        MDUse_ID = 1'b1;
        #1;
        check("dz_stall", {63'd0, MDStall}, 64'd0);
        @(negedge clk);
        start_EX = 1'b0;
        MDOp_EX  = MD_NONE;
        MDUse_ID = 1'b0;
        late = 1'b0;
        repeat (12) begin
            if (busy) late = 1'b1;
            @(negedge clk);
        end
        check("dz_never_busy", {63'd0, late}, 64'd0);
        check("dz_hilo_kept", {HI, LO}, 64'hA5A5_A5A5_0000_0000);
`else
        run_md("div_zero", MD_DIV, 32'h55, 32'd0,
               64'h0000_0055_FFFF_FFFF, 10, 1'b0);
        run_md("divu_zero", MD_DIVU, 32'hF000_0001, 32'd0,
               64'hF000_0001_FFFF_FFFF, 10, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
